// File: rtl/spi_clkgen.sv
// spi_clkgen: programmable SCK divider with CPOL idle level and edge strobes.
// Define SPI_CLKGEN_GAP_EN to add an inter-frame GAP state of GAP_CYC cycles.
module spi_clkgen #(
  parameter int DIV_WIDTH = 16,
  parameter int GAP_CYC   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 last_i,
  input  logic                 cpol_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 spi_clk_o,
  output logic                 pos_edge_o,
  output logic                 neg_edge_o,
  output logic                 idle_o
);

  localparam int GW = $clog2(GAP_CYC + 2);

`ifdef SPI_CLKGEN_GAP_EN
  localparam bit GAP_ON = (GAP_CYC != 0);
`else
  localparam bit GAP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] w_div_nxt;
  logic                 r_cpol;
  logic                 w_cpol_nxt;
  logic [GW-1:0]        r_gap;
  logic [GW-1:0]        w_gap_nxt;

  logic r_clk;
  logic r_pos;
  logic r_neg;
  logic r_idle;
  logic w_clk_nxt;
  logic w_pos_nxt;
  logic w_neg_nxt;
  logic w_idle_nxt;

  logic w_tick;
  logic w_at_idle;
  logic w_stop_req;
  logic w_toggle;

  assign w_tick     = (r_cnt == '0);
  assign w_at_idle  = (r_clk == r_cpol);
  assign w_stop_req = last_i | ~en_i;

  // STOP only divides while SCK is away from its idle level
  assign w_toggle = w_tick &
                    ((r_state == S_RUN) |
                     ((r_state == S_STOP) & ~w_at_idle));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (en_i) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_stop_req) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_at_idle) begin
          w_state_nxt = GAP_ON ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap <= GW'(1)) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_div_nxt  = r_div;
    w_cpol_nxt = r_cpol;
    w_gap_nxt  = r_gap;
    w_clk_nxt  = r_clk;
    w_pos_nxt  = 1'b0;
    w_neg_nxt  = 1'b0;
    w_idle_nxt = (w_state_nxt == S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        w_clk_nxt = cpol_i;
        if (en_i) begin
          w_div_nxt  = div_i;
          w_cpol_nxt = cpol_i;
          w_cnt_nxt  = div_i;
        end
      end
      S_RUN,
      S_STOP: begin
        if (w_tick) begin
          w_cnt_nxt = r_div;
        end else begin
          w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
        end
        if (w_toggle) begin
          w_clk_nxt = ~r_clk;
          w_pos_nxt = ~r_clk;
          w_neg_nxt = r_clk;
        end
        if (w_state_nxt == S_GAP) begin
          w_gap_nxt = GW'(GAP_CYC);
        end
      end
      S_GAP: begin
        w_clk_nxt = r_cpol;
        w_gap_nxt = r_gap - GW'(1);
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt  <= '0;
      r_div  <= '0;
      r_cpol <= 1'b0;
      r_gap  <= '0;
      r_clk  <= 1'b0;
      r_pos  <= 1'b0;
      r_neg  <= 1'b0;
      r_idle <= 1'b1;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_div  <= w_div_nxt;
      r_cpol <= w_cpol_nxt;
      r_gap  <= w_gap_nxt;
      r_clk  <= w_clk_nxt;
      r_pos  <= w_pos_nxt;
      r_neg  <= w_neg_nxt;
      r_idle <= w_idle_nxt;
    end
  end

  assign spi_clk_o  = r_clk;
  assign pos_edge_o = r_pos;
  assign neg_edge_o = r_neg;
  assign idle_o     = r_idle;

endmodule
